// File: rtl/unloc_mech_moore.sv
// Serial combination-lock recogniser: one code bit per valid/ready handshake,
// Moore outputs give a one-cycle unlock/incorrect verdict per attempt.
module unloc_mech_moore #(
    parameter logic [3:0] CODE = 4'b1011
) (
    input  logic clk,
    input  logic rstn,
    input  logic ser_val,
    input  logic ser_data,
    output logic ser_ready,
    output logic output_val,
    output logic output_data
);

    // Left local so verification can reach dut.state / dut.IDLE directly.
    typedef enum logic [2:0] {
        IDLE,
        STATE_A,
        STATE_B,
        STATE_C,
        STATE_D,
        INCORRECT
    } state_t;

    state_t state;
    state_t state_d;
    logic   accept;

    // ser_ready decodes from state only, so this has no input-to-output path.
    assign accept = ser_val && ser_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (accept) state_d = (ser_data == CODE[3]) ? STATE_A : INCORRECT;
            end
            STATE_A: begin
                if (accept) state_d = (ser_data == CODE[2]) ? STATE_B : INCORRECT;
            end
            STATE_B: begin
                if (accept) state_d = (ser_data == CODE[1]) ? STATE_C : INCORRECT;
            end
            STATE_C: begin
                if (accept) state_d = (ser_data == CODE[0]) ? STATE_D : INCORRECT;
            end
            // Verdict states last one cycle and never consume a bit.
            STATE_D:   state_d = IDLE;
            INCORRECT: state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        ser_ready   = 1'b1;
        output_val  = 1'b0;
        output_data = 1'b0;
        case (state)
            STATE_D: begin
                ser_ready   = 1'b0;
                output_val  = 1'b1;
                output_data = 1'b1;
            end
            INCORRECT: begin
                ser_ready   = 1'b0;
                output_val  = 1'b1;
                output_data = 1'b0;
            end
            default: begin
                ser_ready   = 1'b1;
                output_val  = 1'b0;
                output_data = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_unloc_mech_moore.sv
// Directed bench for unloc_mech_moore: stimulus pushes expected verdicts into a
// queue, an independent monitor pops and compares whenever output_val is seen.
module tb_unloc_mech_moore;

    logic clk;
    logic rstn;
    logic ser_val;
    logic ser_data;
    logic ser_ready;
    logic output_val;
    logic output_data;

    int   checks;
    int   failures;
    bit   sb[$];
    bit   prev_val;

    unloc_mech_moore dut (
        .clk        (clk),
        .rstn       (rstn),
        .ser_val    (ser_val),
        .ser_data   (ser_data),
        .ser_ready  (ser_ready),
        .output_val (output_val),
        .output_data(output_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // Monitor: every verdict must match the oldest outstanding expectation
    // and must not be a continuation of the previous cycle's verdict.
    initial prev_val = 1'b0;
    always @(negedge clk) begin
        if (output_val === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL verdict_unexpected: got data=%0b, required no verdict", output_data);
            end else begin
                automatic bit exp = sb.pop_front();
                if (output_data !== exp) begin
                    failures++;
                    $display("FAIL verdict_data: got %0b, required %0b", output_data, exp);
                end else begin
                    $display("verdict data=%0b ok", output_data);
                end
            end
            checks++;
            if (prev_val) begin
                failures++;
                $display("FAIL verdict_width: got output_val high two cycles, required one");
            end
        end
        prev_val = (output_val === 1'b1);
    end

    task automatic expect_out(input string name, input logic r, input logic v, input logic d);
        checks++;
        if (ser_ready !== r || output_val !== v || (v && output_data !== d)) begin
            failures++;
            $display("FAIL %s: got ready=%0b val=%0b data=%0b, required ready=%0b val=%0b data=%0b",
                     name, ser_ready, output_val, output_data, r, v, d);
        end else begin
            $display("%s: ready=%0b val=%0b data=%0b ok", name, ser_ready, output_val, output_data);
        end
    endtask

    // One-cycle pulse; returns at the negedge after the accepting edge.
    task automatic send_bit(input logic b);
        @(negedge clk);
        ser_val  = 1'b1;
        ser_data = b;
        @(negedge clk);
        ser_val  = 1'b0;
        ser_data = $urandom_range(0, 1);
    endtask

    task automatic gap_check(input string name);
        @(negedge clk);
        expect_out(name, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        logic [3:0] code;
        checks   = 0;
        failures = 0;
        code     = 4'b1011;

        // Reset with random inputs.
        rstn     = 1'b0;
        ser_val  = 1'b0;
        ser_data = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ser_val  = $urandom_range(0, 1);
            ser_data = $urandom_range(0, 1);
        end
        #1 expect_out("reset", 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        ser_val = 1'b0;
        rstn    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        expect_out("post_reset_idle", 1'b1, 1'b0, 1'b0);

        // Correct code with a gap after each bit.
        sb.push_back(1'b1);
        for (int i = 3; i >= 1; i--) begin
            send_bit(code[i]);
            expect_out($sformatf("gap_bit%0d", i), 1'b1, 1'b0, 1'b0);
            @(negedge clk);
            expect_out($sformatf("gap_hold%0d", i), 1'b1, 1'b0, 1'b0);
        end
        send_bit(code[0]);
        expect_out("unlock_pulse", 1'b0, 1'b1, 1'b1);
        gap_check("unlock_back_idle");

        // Immediate wrong bit.
        sb.push_back(1'b0);
        send_bit(1'b0);
        expect_out("wrong_first", 1'b0, 1'b1, 1'b0);
        gap_check("wrong_first_idle");

        // Late wrong bit with ser_val held through INCORRECT.
        sb.push_back(1'b0);
        @(negedge clk);
        ser_val  = 1'b1;
        ser_data = 1'b1;
        @(negedge clk);
        @(negedge clk);
        expect_out("wrong_late", 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        ser_val = 1'b0;
        expect_out("wrong_late_idle", 1'b1, 1'b0, 1'b0);

        // Back-to-back code; a wrong bit presented during the verdict is ignored.
        sb.push_back(1'b1);
        @(negedge clk);
        ser_val = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            ser_data = code[i];
            @(negedge clk);
        end
        ser_data = 1'b0;
        expect_out("b2b_unlock", 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        ser_val = 1'b0;
        expect_out("b2b_idle", 1'b1, 1'b0, 1'b0);
        gap_check("b2b_no_consume");

        // Short reset pulse between edges while in STATE_B, then a full code.
        send_bit(1'b1);
        send_bit(1'b0);
        #2 rstn = 1'b0;
        #1 expect_out("async_reset", 1'b1, 1'b0, 1'b0);
        #1 rstn = 1'b1;
        sb.push_back(1'b1);
        for (int i = 3; i >= 1; i--) send_bit(code[i]);
        send_bit(code[0]);
        expect_out("after_reset_unlock", 1'b0, 1'b1, 1'b1);
        gap_check("after_reset_idle");

        // Reset during STATE_D suppresses the verdict.
        for (int i = 3; i >= 1; i--) send_bit(code[i]);
        @(negedge clk);
        ser_val  = 1'b1;
        ser_data = code[0];
        @(posedge clk);
        #1 ser_val = 1'b0;
        rstn = 1'b0;
        #1 expect_out("reset_in_d", 1'b1, 1'b0, 1'b0);
        #1 rstn = 1'b1;
        gap_check("reset_in_d_idle");
        gap_check("reset_in_d_quiet");

        // All expected verdicts must have been observed.
        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL verdicts_missing: got %0d outstanding, required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/unloc_mech_moore.md
Name: unloc_mech_moore

Overview:
- Serial combination-lock recogniser built as a Moore FSM.
- Consumes one code bit per valid/ready handshake on the serial input.
- Reports a one-cycle verdict: unlock or incorrect.
- Sits between the keypad/serial front end and the lock actuator logic.

Parameters:
- CODE, 4'b1011, unlock code; bit 3 is entered first, bit 0 last.

Ports:
- clk  input  1  system clock, rising edge active
- rstn  input  1  asynchronous active-low reset
- ser_val  input  1  serial bit valid
- ser_data  input  1  serial code bit, sampled when ser_val && ser_ready
- ser_ready  output  1  FSM can accept a code bit this cycle
- output_val  output  1  verdict valid; high for exactly one cycle per attempt
- output_data  output  1  verdict value: 1 = unlock, 0 = incorrect; meaningful only when output_val=1

Behaviour:
- Single clock, one registered state variable named `state`.
- `state` uses a module-local enum with enumerators IDLE, STATE_A, STATE_B, STATE_C, STATE_D, INCORRECT. These names are verification-visible and must not be renamed or moved.
- Reset (rstn=0, asynchronous): state=IDLE, so ser_ready=1, output_val=0, output_data=0.
- Accept event: a rising clk edge with ser_val=1 and ser_ready=1.
- Outputs are pure functions of state (Moore); no combinational path from inputs to outputs.
- Output decode per state:
  - IDLE, STATE_A, STATE_B, STATE_C: ser_ready=1, output_val=0, output_data=0
  - STATE_D: ser_ready=0, output_val=1, output_data=1
  - INCORRECT: ser_ready=0, output_val=1, output_data=0
- Transitions, evaluated on an accept event:
  - IDLE: ser_data==CODE[3] -> STATE_A, else -> INCORRECT
  - STATE_A: ser_data==CODE[2] -> STATE_B, else -> INCORRECT
  - STATE_B: ser_data==CODE[1] -> STATE_C, else -> INCORRECT
  - STATE_C: ser_data==CODE[0] -> STATE_D, else -> INCORRECT
- ser_val=0 in IDLE/A/B/C: hold state indefinitely. Gaps between bits are allowed with no timeout.
- STATE_D and INCORRECT: unconditionally return to IDLE on the next edge. ser_val/ser_data are ignored there and no bit is consumed.
- Wrong bit: aborts immediately; the remaining bits of the attempt are not awaited.
- No overlap or partial-match recovery: after INCORRECT the next accepted bit starts a fresh attempt from IDLE.
- Latency: the verdict appears in the cycle after the 4th correct bit is accepted, or after the first wrong bit.
- Reset mid-sequence: return to IDLE immediately and discard partial progress. Reset during STATE_D suppresses the rest of the verdict pulse.
- Illegal or unencoded state value: next state is IDLE; outputs are the IDLE values.
- ser_data when ser_val=0: don't-care and must not affect state.

Decomposition:
- No shared package. The state enum stays local to the module because verification references dut.state and dut.IDLE hierarchically.
- No sub-modules: one state register block, one next-state block, one output-decode block.

Test Plan:
- Reset: rstn=0 with random inputs -> state=IDLE, ser_ready=1, output_val=0. Release rstn and idle 2 cycles -> unchanged.
- Correct code with gaps: bits 1,0,1,1, each as a one-cycle ser_val pulse followed by one ser_val=0 cycle -> state steps IDLE->A->B->C->D. Each state holds during gaps. In D: output_val=1, output_data=1, ser_ready=0 for one cycle, then IDLE.
- Immediate wrong bit: from IDLE, ser_val=1, ser_data=0 -> INCORRECT next cycle (output_val=1, output_data=0), then IDLE.
- Late wrong bit: 1 then 1 -> A, then INCORRECT. Keeping ser_val=1 through INCORRECT does not consume a bit. Next state is IDLE; final check state==IDLE.
- Back-to-back code: ser_val held at 1 with data 1,0,1,1 -> D reached after 4 accepts, verdict pulse of exactly one cycle. The bit presented during D is not accepted.
- Async reset mid-sequence: after 1,0 (STATE_B), assert rstn=0 between clock edges -> IDLE immediately. Then 1,0,1,1 -> unlock.
